// File: rtl/sram_pkg.sv
// Shared definitions for initiators of the S011HD1P single-port bit-write-enable SRAM macros.
// Holds per-variant geometry and the byte-strobe to active-low bit-mask conversion.
package sram_pkg;

  localparam int S011HD1P_X32Y2D128_DATA_W = 128;
  localparam int S011HD1P_X32Y2D128_ADDR_W = 6;
  localparam int S011HD1P_X16Y2D64_DATA_W  = 64;
  localparam int S011HD1P_X16Y2D64_ADDR_W  = 5;

  // Widest macro in the family; narrower initiators zero-extend their strobes
  localparam int SRAM_MAX_DATA_W = 128;
  localparam int SRAM_MAX_STRB_W = SRAM_MAX_DATA_W / 8;

  typedef logic [SRAM_MAX_STRB_W-1:0] sram_strb_t;
  typedef logic [SRAM_MAX_DATA_W-1:0] sram_bwen_t;

  function automatic sram_bwen_t strb2bwen(input sram_strb_t strb);
    sram_bwen_t bwen;
    for (int i = 0; i < SRAM_MAX_STRB_W; i++) begin
      bwen[8*i +: 8] = {8{~strb[i]}};
    end
    return bwen;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small in-order response FIFO (is_wr flag + data) with registered storage and an occupancy count.
// Outputs read as zero while empty so an idle response channel never shows stale data.
module sram_rsp_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              push,
  input  logic              push_is_wr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              rsp_valid,
  output logic              rsp_is_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_W:0]   mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              pop_ok_s;
  logic              push_ok_s;
  logic [DATA_W:0]   head_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PTR_ONE;
  endfunction

  // Qualify pop/push and present the head entry
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    head_s    = {(DATA_W+1){1'b0}};
    if (count_r != {CW{1'b0}}) begin
      pop_ok_s = pop;
      head_s   = mem_r[rd_ptr_r];
    end else begin
      pop_ok_s = 1'b0;
      head_s   = {(DATA_W+1){1'b0}};
    end
    if ((count_r != CNT_FULL) || pop_ok_s) begin
      push_ok_s = push;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(DATA_W+1){1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= {push_is_wr, push_data};
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rsp_valid = (count_r != {CW{1'b0}});
  assign rsp_is_wr = head_s[DATA_W];
  assign rsp_rdata = head_s[DATA_W-1:0];
  assign count     = count_r;

endmodule

// File: rtl/sram_req_bridge.sv
// Valid/ready request channel to S011HD1P macro pin drive, with in-order responses.
// Credits count buffered plus in-flight responses so the FIFO can never overflow.
module sram_req_bridge
  import sram_pkg::*;
#(
  parameter int DATA_W  = S011HD1P_X32Y2D128_DATA_W,
  parameter int ADDR_W  = S011HD1P_X32Y2D128_ADDR_W,
  parameter int RSP_DEP = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_is_wr,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [DATA_W-1:0]   sram_bwen,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [DATA_W-1:0]   sram_d,
  input  logic [DATA_W-1:0]   sram_q
);

  localparam int CW = $clog2(RSP_DEP + 1);
  localparam logic [CW:0] CREDIT_LIM = (CW+1)'(RSP_DEP);

  logic              inflight_r;
  logic              inflight_we_r;
  logic [CW-1:0]     count_s;
  logic              pop_s;
  logic              fire_s;
  logic [CW:0]       used_s;
  sram_strb_t        strb_ext_s;
  sram_bwen_t        bwen_ext_s;
  logic [DATA_W-1:0] push_data_s;

  // Credit check, fire qualification and macro pin drive
  always_comb begin
    pop_s      = rsp_valid & rsp_ready;
    used_s     = {1'b0, count_s} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
    req_ready  = RST_N & (used_s < CREDIT_LIM);
    fire_s     = req_valid & req_ready;
    strb_ext_s = {SRAM_MAX_STRB_W{1'b0}};
    strb_ext_s[DATA_W/8-1:0] = req_wstrb;
    bwen_ext_s = strb2bwen(strb_ext_s);
    sram_a     = req_addr;
    sram_d     = req_wdata;
    sram_cen   = 1'b1;
    sram_wen   = 1'b1;
    sram_bwen  = {DATA_W{1'b1}};
    if (fire_s) begin
      sram_cen  = 1'b0;
      sram_wen  = ~req_we;
      sram_bwen = bwen_ext_s[DATA_W-1:0];
    end else begin
      sram_cen  = 1'b1;
      sram_wen  = 1'b1;
      sram_bwen = {DATA_W{1'b1}};
    end
    if (inflight_we_r) begin
      push_data_s = {DATA_W{1'b0}};
    end else begin
      push_data_s = sram_q;
    end
  end

  // One access outstanding at the macro; Q is valid only the cycle after a read
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inflight_r    <= 1'b0;
      inflight_we_r <= 1'b0;
    end else begin
      inflight_r    <= fire_s;
      inflight_we_r <= fire_s & req_we;
    end
  end

  sram_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEP)
  ) u_rsp_fifo (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .push       (inflight_r),
    .push_is_wr (inflight_we_r),
    .push_data  (push_data_s),
    .pop        (pop_s),
    .rsp_valid  (rsp_valid),
    .rsp_is_wr  (rsp_is_wr),
    .rsp_rdata  (rsp_rdata),
    .count      (count_s)
  );

endmodule

// File: tb/tb_sram_req_bridge.sv
// Directed bench for sram_req_bridge with a behavioural 64x128 bit-write-enable macro model.
module tb_sram_req_bridge;

  localparam int DW = 128;
  localparam int AW = 6;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [15:0]   req_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_is_wr;
  logic [DW-1:0] rsp_rdata;
  logic          sram_cen;
  logic          sram_wen;
  logic [DW-1:0] sram_bwen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic          is_wr;
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  rsp_t rsp_q[$];
  int   fire_q[$];

  localparam logic [DW-1:0] ALL1    = {DW{1'b1}};
  localparam logic [DW-1:0] ALL0    = {DW{1'b0}};
  localparam logic [DW-1:0] WPAT    = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [DW-1:0] WPAT_B0 = 128'h0F0E0D0C0B0A090807060504030201FF;
  localparam logic [DW-1:0] GARBAGE = {4{32'hBAD0BAD0}};

  sram_req_bridge dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_is_wr (rsp_is_wr),
    .rsp_rdata (rsp_rdata),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_bwen (sram_bwen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural macro: Q holds data only in the cycle after a read
  logic [DW-1:0] mem [64];
  always @(posedge CLK) begin
    if (!sram_cen && sram_wen) begin
      sram_q <= mem[sram_a];
    end else begin
      sram_q <= GARBAGE;
    end
    if (!sram_cen && !sram_wen) begin
      mem[sram_a] <= (mem[sram_a] & sram_bwen) | (sram_d & ~sram_bwen);
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {4{24'hC0FFEE, b}};
  endfunction

  // Response/fire collection and idle pin check, sampled mid-cycle
  always @(negedge CLK) begin
    if (RST_N) begin
      if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_is_wr, rsp_rdata, cyc});
      if (req_valid && req_ready) fire_q.push_back(cyc);
    end
    if (req_valid && req_ready) begin
      chk("cen_fire", {127'b0, sram_cen}, ALL0);
    end else begin
      chk("cen_idle", {127'b0, sram_cen}, {127'b0, 1'b1});
      chk("wen_idle", {127'b0, sram_wen}, {127'b0, 1'b1});
      chk("bwen_idle", sram_bwen, ALL1);
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [15:0] s, input logic [DW-1:0] exp_bwen);
    int  k;
    logic nwe;
    nwe       = ~we;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!req_ready && k < 50);
    if (!req_ready) begin
      chk("issue_timeout", {127'b0, req_ready}, {127'b0, 1'b1});
    end else begin
      chk("wen_fire", {127'b0, sram_wen}, {127'b0, nwe});
      chk("bwen_fire", sram_bwen, exp_bwen);
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 300) begin
      @(posedge CLK);
      #1;
      k++;
    end
    if (rsp_q.size() < n) chk("rsp_timeout", DW'(rsp_q.size()), DW'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int fb;
    int drops;
    int acc;
    int k;

    RST_N     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b1;

    // Reset with a pending request
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cen", {127'b0, sram_cen}, {127'b0, 1'b1});
    chk("rst_rsp_valid", {127'b0, rsp_valid}, ALL0);
    chk("rst_rsp_is_wr", {127'b0, rsp_is_wr}, ALL0);
    chk("rst_rsp_rdata", rsp_rdata, ALL0);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    RST_N     = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", {127'b0, req_ready}, {127'b0, 1'b1});
    @(posedge CLK);
    #1;

    // Fill the array with writes, then stream 64 reads back-to-back
    base = rsp_q.size();
    for (int i = 0; i < 64; i++) issue(1'b1, AW'(i), pat(i), 16'hFFFF, ALL0);
    wait_rsp(base + 64);
    for (int i = 0; i < 64 && base + i < rsp_q.size(); i++) begin
      chk("fill_ack", {127'b0, rsp_q[base+i].is_wr}, {127'b0, 1'b1});
      chk("fill_ack_data", rsp_q[base+i].data, ALL0);
    end

    base  = rsp_q.size();
    drops = 0;
    for (int i = 0; i < 64; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = AW'(i);
      req_wstrb = 16'h0000;
      @(negedge CLK);
      if (!req_ready) drops++;
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    chk("stream_ready_drops", DW'(drops), ALL0);
    wait_rsp(base + 64);
    for (int i = 0; i < 64 && base + i < rsp_q.size(); i++) begin
      chk("stream_data", rsp_q[base+i].data, pat(i));
      chk("stream_is_wr", {127'b0, rsp_q[base+i].is_wr}, ALL0);
      if (i > 0) chk("stream_spacing", DW'(rsp_q[base+i].cyc - rsp_q[base+i-1].cyc), DW'(1));
    end

    // Full write then read of address 5, with response latency
    base = rsp_q.size();
    fb   = fire_q.size();
    issue(1'b1, 6'd5, WPAT, 16'hFFFF, ALL0);
    issue(1'b0, 6'd5, ALL0, 16'h0000, ALL1);
    wait_rsp(base + 2);
    if (rsp_q.size() >= base + 2) begin
      chk("wr_ack_is_wr", {127'b0, rsp_q[base].is_wr}, {127'b0, 1'b1});
      chk("wr_ack_data", rsp_q[base].data, ALL0);
      chk("rd_is_wr", {127'b0, rsp_q[base+1].is_wr}, ALL0);
      chk("rd_data", rsp_q[base+1].data, WPAT);
      chk("rd_latency", DW'(rsp_q[base+1].cyc - fire_q[fb+1]), DW'(2));
    end

    // Single-byte write, then zero-strobe write
    base = rsp_q.size();
    issue(1'b1, 6'd5, ALL1, 16'h0001, {{120{1'b1}}, 8'h00});
    issue(1'b0, 6'd5, ALL0, 16'h0000, ALL1);
    issue(1'b1, 6'd5, 128'h123456789ABCDEF0123456789ABCDEF0, 16'h0000, ALL1);
    issue(1'b0, 6'd5, ALL0, 16'h0000, ALL1);
    wait_rsp(base + 4);
    if (rsp_q.size() >= base + 4) begin
      chk("pw_ack", {127'b0, rsp_q[base].is_wr}, {127'b0, 1'b1});
      chk("pw_rd", rsp_q[base+1].data, WPAT_B0);
      chk("zs_ack", {127'b0, rsp_q[base+2].is_wr}, {127'b0, 1'b1});
      chk("zs_ack_data", rsp_q[base+2].data, ALL0);
      chk("zs_rd", rsp_q[base+3].data, WPAT_B0);
    end

    // Backpressure: only two reads fit while responses are held
    rsp_ready = 1'b0;
    base = rsp_q.size();
    acc  = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_wstrb = 16'h0000;
    for (int c = 0; c < 6; c++) begin
      req_addr = AW'(10 + acc);
      @(negedge CLK);
      if (req_ready) acc++;
      @(posedge CLK);
      #1;
    end
    req_addr = AW'(10 + acc);
    chk("bp_accepted", DW'(acc), DW'(2));
    @(negedge CLK);
    chk("bp_ready_low", {127'b0, req_ready}, ALL0);
    chk("bp_rsp_valid", {127'b0, rsp_valid}, {127'b0, 1'b1});
    chk("bp_rdata_hold1", rsp_rdata, pat(10));
    @(negedge CLK);
    chk("bp_rdata_hold2", rsp_rdata, pat(10));
    @(posedge CLK);
    #1;
    rsp_ready = 1'b1;
    k = 0;
    while (acc < 4 && k < 20) begin
      req_addr = AW'(10 + acc);
      @(negedge CLK);
      if (req_ready) acc++;
      @(posedge CLK);
      #1;
      k++;
    end
    req_valid = 1'b0;
    chk("bp_total_accepted", DW'(acc), DW'(4));
    wait_rsp(base + 4);
    for (int i = 0; i < 4 && base + i < rsp_q.size(); i++) begin
      chk("bp_order", rsp_q[base+i].data, pat(10 + i));
    end

    // Reset with one response buffered and one in flight
    rsp_ready = 1'b0;
    issue(1'b0, 6'd20, ALL0, 16'h0000, ALL1);
    issue(1'b0, 6'd21, ALL0, 16'h0000, ALL1);
    RST_N     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 6'd30;
    @(negedge CLK);
    chk("midrst_cen", {127'b0, sram_cen}, {127'b0, 1'b1});
    chk("midrst_rsp_valid", {127'b0, rsp_valid}, ALL0);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    RST_N     = 1'b1;
    rsp_ready = 1'b1;
    base = rsp_q.size();
    repeat (5) @(posedge CLK);
    #1;
    chk("no_stale_rsp", DW'(rsp_q.size()), DW'(base));
    issue(1'b0, 6'd22, ALL0, 16'h0000, ALL1);
    wait_rsp(base + 1);
    if (rsp_q.size() >= base + 1) begin
      chk("post_rst_rd", rsp_q[base].data, pat(22));
      chk("post_rst_is_wr", {127'b0, rsp_q[base].is_wr}, ALL0);
    end
    repeat (3) @(posedge CLK);
    chk("post_rst_count", DW'(rsp_q.size()), DW'(base + 1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
